// File: rtl/fdiv_if.sv
// FDIV operand/result handshake bundle.
// The master drives the operands and takes the quotient. The slave is the divider.
interface fdiv_if;
   logic [31:0] x1;
   logic [31:0] x2;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] y;
   logic        y_valid;
   logic        y_ready;

   modport master (
      output x1, x2, in_valid, y_ready,
      input  in_ready, y, y_valid
   );

   modport slave (
      input  x1, x2, in_valid, y_ready,
      output in_ready, y, y_valid
   );
endinterface

// File: rtl/fdiv.sv
// FDIV: FP32 divider. It uses a 26-step restoring mantissa division and
// round-to-nearest-even.
// Only one operation is in flight at a time. The latency is fixed: y_valid
// rises 27 edges after accept. Zero and divide-by-zero operands take the same
// 27-edge path. Denormals are flushed to zero. Exponent 255 is an ordinary value.
module fdiv (
   input  logic  clk,
   input  logic  rst,
   fdiv_if.slave bus
);

   typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

   state_t      state, state_nxt;
   logic [4:0]  cnt;        // quotient bits produced so far
   logic        sign;
   logic        z1;         // dividend is zero
   logic        z2;         // divisor is zero
   logic [7:0]  e1, e2;
   logic [23:0] m2;         // divisor mantissa with hidden one
   logic [24:0] rem;        // partial remainder, always < 2*m2
   logic [25:0] q;          // quotient bits, MSB first
   logic [31:0] y_q;

   logic        accept;
   logic [25:0] diff;
   logic        ge;

   // Rounding-stage signals
   logic [22:0]        man_pre;
   logic               guard, sticky, inc, carry;
   logic [23:0]        man_sum;
   logic signed [10:0] adj;
   logic signed [10:0] e;
   logic [31:0]        result;

   assign accept = bus.in_valid && (state == IDLE);

   // Every output is decoded from registers only. in_valid and y_ready have
   // no path to any output.
   assign bus.in_ready = (state == IDLE);
   assign bus.y_valid  = (state == DONE);
   assign bus.y        = y_q;

   // State register
   // NOTE: state-holding regs use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   // NOTE: default assigned first so no path through the case leaves state_nxt unassigned (no latch).
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  if (accept)           state_nxt = DIV;
         DIV:   if (cnt == 5'd25)     state_nxt = ROUND;
         ROUND:                       state_nxt = DONE;
         DONE:  if (bus.y_ready)      state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   // Trial subtraction. A clear borrow bit means the remainder covers the divisor.
   always_comb begin
      diff = {1'b0, rem} - {2'b00, m2};
      ge   = ~diff[25];
   end

   // Datapath: capture operands on accept, do one division step per DIV
   // cycle, and register the rounded result on the ROUND edge.
   // NOTE: the datapath is reset as well. A mid-operation reset then leaves no stale partial result behind.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         sign <= 1'b0;
         z1   <= 1'b0;
         z2   <= 1'b0;
         e1   <= '0;
         e2   <= '0;
         m2   <= '0;
         rem  <= '0;
         q    <= '0;
         y_q  <= '0;
      end else begin
         unique case (state)
            IDLE: if (accept) begin
               sign <= bus.x1[31] ^ bus.x2[31];
               z1   <= (bus.x1[30:23] == 8'd0);
               z2   <= (bus.x2[30:23] == 8'd0);
               e1   <= bus.x1[30:23];
               e2   <= bus.x2[30:23];
               rem  <= {2'b01, bus.x1[22:0]};
               m2   <= {1'b1, bus.x2[22:0]};
               q    <= '0;
               cnt  <= '0;
            end
            DIV: begin
               q   <= {q[24:0], ge};
               rem <= ge ? (diff[24:0] << 1) : (rem << 1);
               cnt <= cnt + 5'd1;
            end
            ROUND:   y_q <= result;
            default: ;
         endcase
      end
   end

   // Normalise, round to nearest even, compute the exponent, and select the result
   always_comb begin
      if (q[25]) begin
         man_pre = q[24:2];
         guard   = q[1];
         sticky  = q[0] | (|rem);
         adj     = 11'sd0;
      end else begin
         man_pre = q[23:1];
         guard   = q[0];
         sticky  = |rem;
         adj     = -11'sd1;
      end
      inc     = guard & (sticky | man_pre[0]);
      man_sum = {1'b0, man_pre} + {23'd0, inc};
      carry   = man_sum[23];   // on carry, man_sum[22:0] has wrapped to zero
      e       = $signed({3'b000, e1}) - $signed({3'b000, e2}) + 11'sd127
                + adj + $signed({10'd0, carry});

      if (z1)                 result = 32'h0000_0000;
      else if (z2)            result = {sign, 8'hFF, 23'd0};
      else if (e <= 11'sd0)   result = 32'h0000_0000;
      else if (e >= 11'sd255) result = {sign, 8'hFF, 23'd0};
      else                    result = {sign, e[7:0], man_sum[22:0]};
   end

endmodule

// File: tb/tb_fdiv.sv
// Self-checking bench for fdiv.
// It runs directed and random operand pairs against a reference model that
// does a single integer division.
module tb_fdiv;

   logic clk = 1'b0;
   logic rst;
   int   checks   = 0;
   int   failures = 0;

   fdiv_if bus ();

   fdiv dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   // Reference quotient. It computes q and r with one wide integer division,
   // then applies the normalise/round/exponent/selection rules.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
      longint m1, m2, q, r, man;
      int     g, st, adj, inc, carry, e;
      logic   s;
      s = a[31] ^ b[31];
      if (a[30:23] == 8'd0) return 32'h0000_0000;
      if (b[30:23] == 8'd0) return {s, 8'hFF, 23'd0};
      m1 = longint'({1'b1, a[22:0]});
      m2 = longint'({1'b1, b[22:0]});
      q  = (m1 << 25) / m2;
      r  = (m1 << 25) % m2;
      if (q >= (longint'(1) << 25)) begin
         man = (q >> 2) & 64'h7F_FFFF;
         g   = int'((q >> 1) & 1);
         st  = ((q & 1) != 0 || r != 0) ? 1 : 0;
         adj = 0;
      end else begin
         man = (q >> 1) & 64'h7F_FFFF;
         g   = int'(q & 1);
         st  = (r != 0) ? 1 : 0;
         adj = -1;
      end
      inc   = g & (st | int'(man & 1));
      man   = man + inc;
      carry = ((man >> 23) != 0) ? 1 : 0;
      man   = man & 64'h7F_FFFF;
      e     = int'(a[30:23]) - int'(b[30:23]) + 127 + adj + carry;
      if (e <= 0)   return 32'h0000_0000;
      if (e >= 255) return {s, 8'hFF, 23'd0};
      return {s, 8'(e), 23'(man)};
   endfunction

   // Run one operation: accept, check the latency and the result, hold for
   // `hold` cycles with y_ready low, then hand off.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp_y, held;
      int          n;
      logic        ok;
      exp_y = model(a, b);
      n = 0;
      while (!bus.in_ready && n < 50) begin @(posedge clk); #1; n++; end
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.x1 = a; bus.x2 = b; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      check("accepted", 32'(bus.in_ready), 32'd0);
      n  = 0;
      ok = 1'b1;
      while (!bus.y_valid && n < 40) begin
         if (bus.in_ready) ok = 1'b0;
         bus.x1 = $urandom; bus.x2 = $urandom;   // must not disturb the result in flight
         @(posedge clk); #1; n++;
      end
      check("latency", 32'(n), 32'd27);
      check("busy_not_ready", 32'(ok), 32'd1);
      check($sformatf("y %h/%h", a, b), bus.y, exp_y);
      held = bus.y;
      ok   = 1'b1;
      for (int i = 0; i < hold; i++) begin
         bus.in_valid = (i == 3);
         bus.x1 = $urandom;
         @(posedge clk); #1;
         if (bus.y !== held || bus.y_valid !== 1'b1 || bus.in_ready !== 1'b0) ok = 1'b0;
      end
      bus.in_valid = 1'b0;
      if (hold > 0) check("hold_stable", 32'(ok), 32'd1);
      bus.y_ready = 1'b1;
      @(posedge clk); #1;
      bus.y_ready = 1'b0;
      check("handoff_y_valid", 32'(bus.y_valid), 32'd0);
      check("handoff_in_ready", 32'(bus.in_ready), 32'd1);
      check("y_kept", bus.y, exp_y);
   endtask

   initial begin
      logic [31:0] a, b;
      logic        seen;
      bus.x1 = '0; bus.x2 = '0; bus.in_valid = 1'b0; bus.y_ready = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_y", bus.y, 32'h0);
      check("rst_y_valid", 32'(bus.y_valid), 32'd0);
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Directed cases
      run_op(32'h40C0_0000, 32'h4000_0000, 0);   // 6/2 = 3
      check("model_6_2", model(32'h40C0_0000, 32'h4000_0000), 32'h4040_0000);
      run_op(32'h3F80_0000, 32'h4040_0000, 0);   // 1/3
      run_op(32'h0000_0000, 32'h4000_0000, 0);
      run_op(32'hBF80_0000, 32'h0000_0000, 0);
      run_op(32'h0080_0000, 32'h7F00_0000, 0);   // underflow
      run_op(32'h7F00_0000, 32'h0080_0000, 0);   // overflow
      run_op(32'h40C0_0000, 32'h4000_0000, 10);  // long hold with ignored in_valid

      // Reset in the middle of DIV
      bus.x1 = 32'h3F80_0000; bus.x2 = 32'h4040_0000; bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_y_valid", 32'(bus.y_valid), 32'd0);
      check("midrst_y", bus.y, 32'h0);
      @(posedge clk); #1 rst = 1'b0;
      seen = 1'b0;
      repeat (40) begin @(posedge clk); #1; if (bus.y_valid) seen = 1'b1; end
      check("midrst_no_pulse", 32'(seen), 32'd0);
      run_op(32'h40C0_0000, 32'h4000_0000, 0);

      // Random operand pairs, with an occasional forced zero exponent
      for (int k = 0; k < 40; k++) begin
         a = $urandom; b = $urandom;
         if ($urandom_range(0, 7) == 0) a[30:23] = 8'd0;
         if ($urandom_range(0, 7) == 0) b[30:23] = 8'd0;
         if ($urandom_range(0, 1) == 0) begin
            a[30:23] = 8'(112 + $urandom_range(0, 31));
            b[30:23] = 8'(112 + $urandom_range(0, 31));
         end
         run_op(a, b, int'($urandom_range(0, 4)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
